// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC core control path.
package npc_pkg;

  localparam int PC_W = 32;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_ERR   = 3'd6
  } seq_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_FTO      = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  // Instructions are 32-bit aligned; compressed encodings are not supported.
  function automatic logic is_misaligned(input pc_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/npc_next_pc.sv
// Next-PC selection: trap > return > branch > sequential, plus alignment check.
module npc_next_pc
  import npc_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic            ecall_taken_i,
  input  logic [PC_W-1:0] ecall_target_i,
  input  logic            mret_taken_i,
  input  logic [PC_W-1:0] mret_target_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            misaligned_o
);

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    if (ecall_taken_i) begin
      next_pc_o = ecall_target_i;
    end else if (mret_taken_i) begin
      next_pc_o = mret_target_i;
    end else if (branch_taken_i) begin
      next_pc_o = branch_target_i;
    end
  end

  assign misaligned_o = is_misaligned(next_pc_o);

endmodule

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> (MEM) -> WB, owns the PC.
module npc_seq_ctrl
  import npc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned     FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ifu_req,
  output logic [PC_W-1:0] ifu_addr,
  input  logic            ifu_rvalid,
  input  logic [31:0]     ifu_rdata,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] pc,
  input  logic            dec_mem,
  input  logic            ebreak_en,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            ecall_taken,
  input  logic [PC_W-1:0] ecall_target,
  input  logic            mret_taken,
  input  logic [PC_W-1:0] mret_target,
  output logic            exu_en,
  output logic            lsu_req,
  input  logic            lsu_done,
  output logic            rf_wen_gate,
  output logic            halted,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [31:0]     inst_cnt
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] next_pc_q, next_pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     wait_q, wait_d;
  logic [31:0]     wait_inc;
  logic [1:0]      err_code_q, err_code_d;

  logic [PC_W-1:0] sel_pc;
  logic            sel_misaligned;

  npc_next_pc u_next_pc (
    .pc_i            (pc_q),
    .ecall_taken_i   (ecall_taken),
    .ecall_target_i  (ecall_target),
    .mret_taken_i    (mret_taken),
    .mret_target_i   (mret_target),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .next_pc_o       (sel_pc),
    .misaligned_o    (sel_misaligned)
  );

  assign wait_inc = wait_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    next_pc_d  = next_pc_q;
    inst_d     = inst_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    err_code_d = err_code_q;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          wait_d  = '0;
          state_d = S_EXEC;
        end else begin
          wait_d = wait_inc;
          if (wait_inc >= FETCH_TIMEOUT) begin
            state_d    = S_ERR;
            err_code_d = ERR_FTO;
          end
        end
      end
      S_EXEC: begin
        // EBREAK wins over a bad redirect so the debugger sees the halting PC.
        next_pc_d = sel_pc;
        if (ebreak_en) begin
          state_d = S_HALT;
        end else if (sel_misaligned) begin
          state_d    = S_ERR;
          err_code_d = ERR_MISALIGN;
        end else if (dec_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_done) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = next_pc_q;
        cnt_d   = cnt_q + 32'd1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      pc_q       <= RESET_PC;
      next_pc_q  <= RESET_PC;
      inst_q     <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      next_pc_q  <= next_pc_d;
      inst_q     <= inst_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      err_code_q <= err_code_d;
    end
  end

  // Strobes and sticky flags are pure decodes of the state register.
  assign ifu_req     = (state_q == S_FETCH);
  assign exu_en      = (state_q == S_EXEC);
  assign lsu_req     = (state_q == S_MEM);
  assign rf_wen_gate = (state_q == S_WB);
  assign halted      = (state_q == S_HALT);
  assign err         = (state_q == S_ERR);

  assign ifu_addr = pc_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign inst_cnt = cnt_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Randomized bench for npc_seq_ctrl against a per-instruction transaction model.
module tb_npc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        dec_mem;
  logic        ebreak_en;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ecall_taken;
  logic [31:0] ecall_target;
  logic        mret_taken;
  logic [31:0] mret_target;
  logic        exu_en;
  logic        lsu_req;
  logic        lsu_done;
  logic        rf_wen_gate;
  logic        halted;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] inst_cnt;

  always #5 clk = ~clk;

  npc_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req       (ifu_req),
    .ifu_addr      (ifu_addr),
    .ifu_rvalid    (ifu_rvalid),
    .ifu_rdata     (ifu_rdata),
    .inst          (inst),
    .pc            (pc),
    .dec_mem       (dec_mem),
    .ebreak_en     (ebreak_en),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ecall_taken   (ecall_taken),
    .ecall_target  (ecall_target),
    .mret_taken    (mret_taken),
    .mret_target   (mret_target),
    .exu_en        (exu_en),
    .lsu_req       (lsu_req),
    .lsu_done      (lsu_done),
    .rf_wen_gate   (rf_wen_gate),
    .halted        (halted),
    .err           (err),
    .err_code      (err_code),
    .inst_cnt      (inst_cnt)
  );

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  int          cmp_cnt = 0;
  int          mis_cnt = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    cmp_cnt++;
    if (obs !== exp_v) begin
      mis_cnt++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] b32(input logic b);
    return {31'b0, b};
  endfunction

  task automatic clear_inputs();
    ifu_rvalid    = 1'b0;
    ifu_rdata     = '0;
    dec_mem       = 1'b0;
    ebreak_en     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    ecall_taken   = 1'b0;
    ecall_target  = '0;
    mret_taken    = 1'b0;
    mret_target   = '0;
    lsu_done      = 1'b0;
  endtask

  // Leaves the bench at a falling edge with the DUT in its first FETCH cycle.
  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_cnt", inst_cnt, 32'h0);
    chk("rst_halted", b32(halted), 32'h0);
    chk("rst_err", b32(err), 32'h0);
    chk("rst_err_code", {30'b0, err_code}, 32'h0);
    chk("rst_strobes", {28'b0, ifu_req, exu_en, lsu_req, rf_wen_gate}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    m_pc  = RST_PC;
    m_cnt = '0;
  endtask

  // One instruction: w fetch wait cycles, m MEM cycles when mem is set.
  task automatic run_inst(input string tag, input int w, input bit mem, input int m,
                          input bit ec, input logic [31:0] et,
                          input bit mr, input logic [31:0] mt,
                          input bit br, input logic [31:0] bt, input bit eb);
    logic [31:0] iw, nxt;
    int          kind, total, nf, nx, nl, nw;
    iw   = $urandom;
    nxt  = ec ? et : (mr ? mt : (br ? bt : m_pc + 32'd4));
    kind = eb ? 1 : ((nxt % 4) != 0 ? 2 : 0);
    total = (kind == 0) ? (3 + w + (mem ? m : 0)) : (w + 2);
    ecall_taken = ec;  ecall_target  = et;
    mret_taken  = mr;  mret_target   = mt;
    branch_taken = br; branch_target = bt;
    ebreak_en = eb;    dec_mem = mem;
    nf = 0; nx = 0; nl = 0; nw = 0;
    for (int c = 0; c < total; c++) begin
      if (ifu_req) begin
        if (nf == 0) chk({tag, "_ifu_addr"}, ifu_addr, m_pc);
        ifu_rvalid = (nf == w);
        ifu_rdata  = (nf == w) ? iw : $urandom;
        nf++;
      end else begin
        ifu_rvalid = 1'($urandom);
        ifu_rdata  = $urandom;
      end
      if (lsu_req) begin
        lsu_done = (nl == m - 1);
        nl++;
      end else begin
        lsu_done = 1'($urandom);
      end
      if (exu_en) nx++;
      if (rf_wen_gate) nw++;
      @(negedge clk);
    end
    ifu_rvalid = 1'b0;
    lsu_done   = 1'b0;
    if (kind == 0) begin
      m_pc  = nxt;
      m_cnt = m_cnt + 32'd1;
    end
    chk({tag, "_fetch_cycles"}, nf, w + 1);
    chk({tag, "_exu_pulses"}, nx, 1);
    chk({tag, "_lsu_cycles"}, nl, (kind == 0 && mem) ? m : 0);
    chk({tag, "_wen_pulses"}, nw, (kind == 0) ? 1 : 0);
    chk({tag, "_inst"}, inst, iw);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_cnt"}, inst_cnt, m_cnt);
    chk({tag, "_ifu_req"}, b32(ifu_req), b32(kind == 0));
    chk({tag, "_halted"}, b32(halted), b32(kind == 1));
    chk({tag, "_err"}, b32(err), b32(kind == 2));
    chk({tag, "_err_code"}, {30'b0, err_code}, (kind == 2) ? 32'd2 : 32'd0);
  endtask

  // Terminal states: nothing may strobe and the PC must stay put.
  task automatic check_idle(input string tag, input int n);
    int act;
    act = 0;
    for (int c = 0; c < n; c++) begin
      ifu_rvalid = 1'($urandom);
      ifu_rdata  = $urandom;
      lsu_done   = 1'($urandom);
      if (ifu_req || exu_en || lsu_req || rf_wen_gate) act++;
      @(negedge clk);
    end
    ifu_rvalid = 1'b0;
    lsu_done   = 1'b0;
    chk({tag, "_idle_strobes"}, act, 0);
    chk({tag, "_idle_pc"}, pc, m_pc);
  endtask

  initial begin
    logic [31:0] t0, t1, t2;
    int n;
    rst_n = 1'b0;
    clear_inputs();
    apply_reset();

    run_inst("first_addi", 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("first_addi_pc_abs", pc, 32'h8000_0004);
    run_inst("slow_load", 0, 1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    run_inst("ecall_vs_br", 1, 1'b0, 0, 1'b1, 32'h8000_1000, 1'b0, 0, 1'b1, 32'h8000_0200, 1'b0);
    chk("ecall_vs_br_abs", pc, 32'h8000_1000);
    run_inst("mret_only", 0, 1'b0, 0, 1'b0, 0, 1'b1, 32'h8000_0040, 1'b0, 0, 1'b0);
    chk("mret_only_abs", pc, 32'h8000_0040);

    for (int i = 0; i < 50; i++) begin
      t0 = $urandom; t0[1:0] = 2'b00;
      t1 = $urandom; t1[1:0] = 2'b00;
      t2 = $urandom; t2[1:0] = 2'b00;
      run_inst("rand",
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 30)) : int'($urandom_range(0, 3)),
               1'($urandom), int'($urandom_range(1, 6)),
               ($urandom_range(0, 3) == 0), t0,
               ($urandom_range(0, 3) == 0), t1,
               ($urandom_range(0, 2) == 0), t2, 1'b0);
    end

    run_inst("to_top", 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_inst("wrap", 2, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("wrap_abs", pc, 32'h0000_0000);

    // Asynchronous reset in the middle of a memory access.
    dec_mem    = 1'b1;
    ifu_rvalid = 1'b1;
    ifu_rdata  = $urandom;
    lsu_done   = 1'b0;
    n = 0;
    while (!lsu_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("arst_in_mem", b32(lsu_req), 32'h1);
    chk("arst_pre_pc", pc, m_pc);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lsu_req", b32(lsu_req), 32'h0);
    chk("arst_pc", pc, RST_PC);
    chk("arst_cnt", inst_cnt, 32'h0);
    apply_reset();

    run_inst("pre_misal", 0, 1'b1, 1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    run_inst("misal", 1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 32'h8000_0102, 1'b0);
    check_idle("misal", 20);
    chk("misal_err_code_held", {30'b0, err_code}, 32'd2);

    apply_reset();
    ifu_rvalid = 1'b0;
    n = 0;
    while (ifu_req && n < 400) begin
      lsu_done = 1'($urandom);
      @(negedge clk);
      n++;
    end
    lsu_done = 1'b0;
    chk("fto_wait_cycles", n, 255);
    chk("fto_err", b32(err), 32'h1);
    chk("fto_err_code", {30'b0, err_code}, 32'd1);
    check_idle("fto", 10);

    apply_reset();
    run_inst("pre_ebreak", 3, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    run_inst("ebreak", 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 32'h8000_0102, 1'b1);
    check_idle("ebreak", 30);
    chk("ebreak_halted_held", b32(halted), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
